// File: rtl/matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// matrix_result_streamer
//
// Purpose:
//   This block sits on the drain side of matrix_multiplier. On each new
//   completion (a rising edge of done) it takes a snapshot of the nine product
//   elements. It then sends them out one per transfer, in row-major order, over
//   a valid/ready handshake. A narrow consumer can then read the 3x3 result
//   without sampling nine parallel buses.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-high
//   done                 completion flag from the multiplier (pulse or level)
//   M0_out..M8_out       product elements c00..c22, DATA_W bits each
//   out_data             element currently offered
//   out_valid            out_data / out_index / out_last are meaningful
//   out_ready            consumer accepts the offered element
//   out_index            position of the offered element, 0..8
//   out_last             offered element is index 8
//   busy                 a snapshot is being streamed
//   overrun              sticky: a completion arrived mid-stream and was dropped
//
// State table:
//   IDLE | no snapshot held; waiting for a completion edge
//   SEND | offering snapshot[out_index]; advancing on each accepted transfer
// -----------------------------------------------------------------------------
module matrix_result_streamer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [DATA_W-1:0] M0_out,
    input  logic [DATA_W-1:0] M1_out,
    input  logic [DATA_W-1:0] M2_out,
    input  logic [DATA_W-1:0] M3_out,
    input  logic [DATA_W-1:0] M4_out,
    input  logic [DATA_W-1:0] M5_out,
    input  logic [DATA_W-1:0] M6_out,
    input  logic [DATA_W-1:0] M7_out,
    input  logic [DATA_W-1:0] M8_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam logic [3:0] LAST_IDX = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] snap   [9];
    logic [DATA_W-1:0] in_bus [9];
    logic              done_q;
    logic              evt;
    logic              xfer;
    logic              at_last;
    logic [3:0]        next_index;

    always_comb begin
        in_bus[0] = M0_out;
        in_bus[1] = M1_out;
        in_bus[2] = M2_out;
        in_bus[3] = M3_out;
        in_bus[4] = M4_out;
        in_bus[5] = M5_out;
        in_bus[6] = M6_out;
        in_bus[7] = M7_out;
        in_bus[8] = M8_out;
    end

    // done_q resets high, so a done level held through reset is not treated
    // as a new completion.
    assign evt        = done & ~done_q;
    assign xfer       = out_valid & out_ready;
    assign at_last    = (out_index == LAST_IDX);
    assign next_index = out_index + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= 4'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                snap[k] <= '0;
            end
        end else begin
            done_q <= done;
            case (state)
                IDLE: begin
                    if (evt) begin
                        for (int k = 0; k < 9; k++) begin
                            snap[k] <= in_bus[k];
                        end
                        out_data  <= in_bus[0];
                        out_index <= 4'd0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (xfer && at_last) begin
                        if (evt) begin
                            // A completion that lands exactly on the final
                            // transfer is taken without a bubble, so it is
                            // not an overrun.
                            for (int k = 0; k < 9; k++) begin
                                snap[k] <= in_bus[k];
                            end
                            out_data  <= in_bus[0];
                            out_index <= 4'd0;
                            out_last  <= 1'b0;
                        end else begin
                            out_data  <= '0;
                            out_index <= 4'd0;
                            out_last  <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            out_index <= next_index;
                            out_data  <= snap[next_index];
                            out_last  <= (next_index == LAST_IDX);
                        end
                        if (evt) begin
                            overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;

    localparam logic [7:0] EX [9] = '{8'h40, 8'h42, 8'h42, 8'h00, 8'h38,
                                      8'h38, 8'h34, 8'h20, 8'h20};

    logic       clk = 1'b0;
    logic       reset;
    logic       done;
    logic       out_ready;
    logic [7:0] m [9];
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] out_index;
    logic       out_last;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    matrix_result_streamer #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .M0_out    (m[0]),
        .M1_out    (m[1]),
        .M2_out    (m[2]),
        .M3_out    (m[3]),
        .M4_out    (m[4]),
        .M5_out    (m[5]),
        .M6_out    (m[6]),
        .M7_out    (m[7]),
        .M8_out    (m[8]),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the snapshot still to be delivered is a queue. The
    // head of the queue is the offered element, and its size gives the index.
    logic [7:0] mq [$];
    bit         mdone_prev = 1'b1;
    bit         mov = 1'b0;

    // These are the transfers seen at the DUT pins, taken from the outputs
    // before each edge.
    logic [7:0] dut_sink [$];
    logic [3:0] idx_sink [$];
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    logic [3:0] pi = '0;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        bit evt;
        bit tr;
        int n;
        if (!reset && pv && out_ready) begin
            dut_sink.push_back(pd);
            idx_sink.push_back(pi);
        end
        if (reset) begin
            mq.delete();
            mdone_prev = 1'b1;
            mov = 1'b0;
        end else begin
            evt = done && !mdone_prev;
            mdone_prev = done;
            n = mq.size();
            tr = (n > 0) && out_ready;
            if (tr) void'(mq.pop_front());
            if (evt) begin
                if (n == 0 || (tr && n == 1)) begin
                    mq.delete();
                    for (int i = 0; i < 9; i++) mq.push_back(m[i]);
                end else begin
                    mov = 1'b1;
                end
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("busy", {31'd0, busy}, {31'd0, mq.size() > 0});
        chk("overrun", {31'd0, overrun}, {31'd0, mov});
        chk("out_index", {28'd0, out_index}, (mq.size() > 0) ? 32'(9 - mq.size()) : 32'd0);
        chk("out_last", {31'd0, out_last}, {31'd0, mq.size() == 1});
        if (mq.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, mq[0]});
        if (busy) busy_cnt++;
        pv = out_valid;
        pd = out_data;
        pi = out_index;
    end

    task automatic set_m(input logic [7:0] v);
        for (int i = 0; i < 9; i++) m[i] = v;
    endtask

    task automatic set_ex();
        for (int i = 0; i < 9; i++) m[i] = EX[i];
    endtask

    task automatic clear_sink();
        dut_sink.delete();
        idx_sink.delete();
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic wait_idx(input logic [3:0] idx, input string nm);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid && out_index == idx) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: index %0d never offered, out_index=%0d", nm, idx, out_index);
    endtask

    task automatic chk_ex_stream(input string nm, input int base);
        chk({nm, "_count"}, 32'(dut_sink.size()), 32'(base + 9));
        for (int i = 0; i < 9; i++) begin
            if (base + i < dut_sink.size()) begin
                chk({nm, "_data"}, {24'd0, dut_sink[base + i]}, {24'd0, EX[i]});
                chk({nm, "_idx"}, {28'd0, idx_sink[base + i]}, 32'(i));
            end
        end
    endtask

    initial begin
        int sz;
        reset = 1'b1;
        done = 1'b0;
        out_ready = 1'b0;
        set_ex();
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_index", {28'd0, out_index}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Worked example from the multiplier, with the consumer always ready.
        clear_sink();
        out_ready = 1'b1;
        @(negedge clk);
        busy_cnt = 0;
        pulse_done();
        repeat (14) @(negedge clk);
        chk_ex_stream("example", 0);
        chk("example_busy_cycles", 32'(busy_cnt), 32'd9);
        chk("example_overrun", {31'd0, overrun}, 32'd0);

        // Backpressure with a 1,0,0 ready pattern.
        clear_sink();
        out_ready = 1'b0;
        pulse_done();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            out_ready = (k % 3 == 0);
        end
        out_ready = 1'b1;
        chk_ex_stream("backpressure", 0);

        // done held high for 30 cycles while the inputs change after capture.
        clear_sink();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        set_m(8'h30);
        repeat (29) @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        chk_ex_stream("held_done", 0);
        chk("held_overrun", {31'd0, overrun}, 32'd0);
        set_ex();

        // Overrun: a second completion arrives while index 3 is offered.
        clear_sink();
        pulse_done();
        wait_idx(4'd3, "overrun_wait");
        set_m(8'h30);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (12) @(negedge clk);
        chk_ex_stream("overrun_stream", 0);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);
        set_ex();

        // Back-to-back: the completion coincides with the index-8 transfer.
        clear_sink();
        @(negedge clk);
        busy_cnt = 0;
        pulse_done();
        wait_idx(4'd8, "b2b_wait");
        set_m(8'h34);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_index", {28'd0, out_index}, 32'd0);
        chk("b2b_data", {24'd0, out_data}, 32'h34);
        repeat (12) @(negedge clk);
        chk("b2b_count", 32'(dut_sink.size()), 32'd18);
        for (int i = 9; i < 18 && i < dut_sink.size(); i++)
            chk("b2b_second", {24'd0, dut_sink[i]}, 32'h34);
        chk("b2b_busy_cycles", 32'(busy_cnt), 32'd18);
        chk("b2b_overrun", {31'd0, overrun}, 32'd0);
        set_ex();

        // Reset mid-stream while index 5 is offered.
        clear_sink();
        pulse_done();
        wait_idx(4'd5, "rst_mid_wait");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        chk("midrst_index", {28'd0, out_index}, 32'd0);
        chk("midrst_last", {31'd0, out_last}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        sz = dut_sink.size();
        chk("midrst_sent", 32'(sz), 32'd5);
        repeat (15) @(negedge clk);
        chk("midrst_no_more", 32'(dut_sink.size()), 32'd5);

        // done held high through the release of reset.
        done = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("held_rst_busy", {31'd0, busy}, 32'd0);
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        chk("held_rst_capture", {31'd0, out_valid}, 32'd1);
        chk("held_rst_capture_idx", {28'd0, out_index}, 32'd0);
        done = 1'b0;
        repeat (12) @(negedge clk);

        // Random traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) done = ~done;
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        done = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
